// File: rtl/rv_wb_pkg.sv
// Shared types for the register writeback buffer.
//   wb_entry_t : one queued register-file write (destination index + value)
//   wb_state_t : drain FSM states
package rv_wb_pkg;

    localparam int REG_IDX_W = 5;
    localparam int XLEN      = 32;

    typedef struct packed {
        logic [REG_IDX_W-1:0] rd;
        logic [XLEN-1:0]      data;
    } wb_entry_t;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } wb_state_t;

    function automatic wb_entry_t make_entry(input logic [REG_IDX_W-1:0] rd,
                                             input logic [XLEN-1:0]      data);
        wb_entry_t e;
        e.rd   = rd;
        e.data = data;
        return e;
    endfunction

endpackage

// File: rtl/reg_writeback_if.sv
// Bus bundle for reg_writeback.
//   producers : lsu_* and alu_* valid/rd/data in, ready out
//   regfile   : stb_write_o/op_rd_o/reg_rd_o out, ack_write_i in
//   forwarding: fwd_rs1_i/fwd_rs2_i in, hit/data out
//   status    : count_o, err_timeout_o
// modport slave is the writeback buffer, modport master is its environment.
interface reg_writeback_if #(parameter int DEPTH = 4);
    import rv_wb_pkg::*;

    localparam int CW = $clog2(DEPTH) + 1;

    logic                 lsu_valid_i;
    logic [REG_IDX_W-1:0] lsu_rd_i;
    logic [XLEN-1:0]      lsu_data_i;
    logic                 lsu_ready_o;
    logic                 alu_valid_i;
    logic [REG_IDX_W-1:0] alu_rd_i;
    logic [XLEN-1:0]      alu_data_i;
    logic                 alu_ready_o;
    logic                 stb_write_o;
    logic [REG_IDX_W-1:0] op_rd_o;
    logic [XLEN-1:0]      reg_rd_o;
    logic                 ack_write_i;
    logic [REG_IDX_W-1:0] fwd_rs1_i;
    logic [REG_IDX_W-1:0] fwd_rs2_i;
    logic                 fwd_hit1_o;
    logic [XLEN-1:0]      fwd_data1_o;
    logic                 fwd_hit2_o;
    logic [XLEN-1:0]      fwd_data2_o;
    logic [CW-1:0]        count_o;
    logic                 err_timeout_o;

    modport master (
        output lsu_valid_i, lsu_rd_i, lsu_data_i,
        output alu_valid_i, alu_rd_i, alu_data_i,
        output ack_write_i, fwd_rs1_i, fwd_rs2_i,
        input  lsu_ready_o, alu_ready_o,
        input  stb_write_o, op_rd_o, reg_rd_o,
        input  fwd_hit1_o, fwd_data1_o, fwd_hit2_o, fwd_data2_o,
        input  count_o, err_timeout_o
    );

    modport slave (
        input  lsu_valid_i, lsu_rd_i, lsu_data_i,
        input  alu_valid_i, alu_rd_i, alu_data_i,
        input  ack_write_i, fwd_rs1_i, fwd_rs2_i,
        output lsu_ready_o, alu_ready_o,
        output stb_write_o, op_rd_o, reg_rd_o,
        output fwd_hit1_o, fwd_data1_o, fwd_hit2_o, fwd_data2_o,
        output count_o, err_timeout_o
    );

endinterface

// File: rtl/reg_writeback_fifo.sv
// wb_fifo: circular buffer of pending register writes.
//   push0_i/push0_entry_i : first (older) write this cycle, lands at the tail
//   push1_i/push1_entry_i : second (younger) write, lands behind push0 if both
//   pop_i                 : drop the head entry
//   head_o, count_o       : oldest entry and occupancy
//   ordered_o/occ_o       : entries re-indexed by age (0 = oldest) with a
//                           valid bit each, for the forwarding search
// The caller guarantees pushes never exceed free space and pops never
// happen when empty.
module wb_fifo
    import rv_wb_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          push0_i,
    input  wb_entry_t     push0_entry_i,
    input  logic          push1_i,
    input  wb_entry_t     push1_entry_i,
    input  logic          pop_i,
    output wb_entry_t     head_o,
    output logic [CW-1:0] count_o,
    output wb_entry_t     ordered_o [DEPTH],
    output logic [DEPTH-1:0] occ_o
);

    wb_entry_t     mem_q [DEPTH];
    wb_entry_t     mem_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] slot1_ptr;

    // The second write goes one slot further only if the first one was taken.
    assign slot1_ptr = wr_ptr_q + PW'(push0_i);

    always_comb begin
        mem_d = mem_q;
        if (push0_i) mem_d[wr_ptr_q]  = push0_entry_i;
        if (push1_i) mem_d[slot1_ptr] = push1_entry_i;
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push0_i) + PW'(push1_i);
        rd_ptr_d = rd_ptr_q + PW'(pop_i);
        count_d  = count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
    end

    // Payload storage carries no reset: occupancy is tracked by count_q alone.
    always_ff @(posedge clk_i) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_view
            assign ordered_o[gi] = mem_q[rd_ptr_q + PW'(gi)];
            assign occ_o[gi]     = (CW'(gi) < count_q);
        end
    endgenerate

endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: in-order writeback buffer in front of the register file.
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   wb            : reg_writeback_if.slave bundle (producers, register-file
//                   strobe/ack port, forwarding lookups, status)
// Results from the LSU and ALU are queued (LSU older when both arrive),
// drained one at a time with a single-cycle strobe, and any pending value
// can be forwarded to the operand-read path.
module reg_writeback
    import rv_wb_pkg::*;
#(
    parameter int DEPTH       = 4,
    parameter int ACK_TIMEOUT = 15
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    reg_writeback_if.slave wb
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    wb_entry_t            fifo_head;
    wb_entry_t            fifo_view [DEPTH];
    logic [DEPTH-1:0]     fifo_occ;
    logic [CW-1:0]        count;
    logic [CW-1:0]        free;
    logic                 lsu_ready, alu_ready;
    logic                 push0, push1, pop;

    wb_state_t            state_q, state_d;
    logic                 stb_q, stb_d;
    logic [REG_IDX_W-1:0] op_rd_q, op_rd_d;
    logic [XLEN-1:0]      reg_rd_q, reg_rd_d;
    logic [TW-1:0]        timer_q, timer_d;
    logic                 err_q, err_d;

    // Ready uses the count before any same-cycle pop, so a full buffer
    // never accepts on the cycle it drains.
    assign free      = CW'(DEPTH) - count;
    assign lsu_ready = (free >= CW'(1));
    // The ALU only gets a slot the LSU is not already claiming.
    assign alu_ready = wb.lsu_valid_i ? (free >= CW'(2)) : (free >= CW'(1));

    // Writes to x0 are handshaken but discarded.
    assign push0 = wb.lsu_valid_i && lsu_ready && (wb.lsu_rd_i != '0);
    assign push1 = wb.alu_valid_i && alu_ready && (wb.alu_rd_i != '0);

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk_i         (clk_i),
        .rst_ni        (rst_ni),
        .push0_i       (push0),
        .push0_entry_i (make_entry(wb.lsu_rd_i, wb.lsu_data_i)),
        .push1_i       (push1),
        .push1_entry_i (make_entry(wb.alu_rd_i, wb.alu_data_i)),
        .pop_i         (pop),
        .head_o        (fifo_head),
        .count_o       (count),
        .ordered_o     (fifo_view),
        .occ_o         (fifo_occ)
    );

    always_comb begin
        state_d  = state_q;
        stb_d    = 1'b0;
        op_rd_d  = op_rd_q;
        reg_rd_d = reg_rd_q;
        timer_d  = timer_q;
        err_d    = err_q;
        pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (count != '0) begin
                    state_d  = WAIT_ACK;
                    stb_d    = 1'b1;
                    op_rd_d  = fifo_head.rd;
                    reg_rd_d = fifo_head.data;
                    timer_d  = '0;
                end
            end
            WAIT_ACK: begin
                if (wb.ack_write_i) begin
                    pop     = 1'b1;
                    state_d = IDLE;
                end else begin
                    // Saturating timer; the error flag is raised on the edge
                    // where the timer reaches the limit and stays set.
                    if (timer_q != TW'(ACK_TIMEOUT)) timer_d = timer_q + TW'(1);
                    if (timer_q == TW'(ACK_TIMEOUT - 1)) err_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= IDLE;
            stb_q    <= 1'b0;
            op_rd_q  <= '0;
            reg_rd_q <= '0;
            timer_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            stb_q    <= stb_d;
            op_rd_q  <= op_rd_d;
            reg_rd_q <= reg_rd_d;
            timer_q  <= timer_d;
            err_q    <= err_d;
        end
    end

    // Two identical lookups. Scanning oldest to youngest lets the youngest
    // match overwrite older ones.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic [REG_IDX_W-1:0] rs;
            logic                 hit;
            logic [XLEN-1:0]      data;

            assign rs = (gi == 0) ? wb.fwd_rs1_i : wb.fwd_rs2_i;

            always_comb begin
                hit  = 1'b0;
                data = '0;
                for (int k = 0; k < DEPTH; k++) begin
                    if (fifo_occ[k] && (fifo_view[k].rd == rs) && (rs != '0)) begin
                        hit  = 1'b1;
                        data = fifo_view[k].data;
                    end
                end
            end
        end
    endgenerate

    assign wb.lsu_ready_o   = lsu_ready;
    assign wb.alu_ready_o   = alu_ready;
    assign wb.stb_write_o   = stb_q;
    assign wb.op_rd_o       = op_rd_q;
    assign wb.reg_rd_o      = reg_rd_q;
    assign wb.fwd_hit1_o    = g_fwd[0].hit;
    assign wb.fwd_data1_o   = g_fwd[0].data;
    assign wb.fwd_hit2_o    = g_fwd[1].hit;
    assign wb.fwd_data2_o   = g_fwd[1].data;
    assign wb.count_o       = count;
    assign wb.err_timeout_o = err_q;

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback: a vector table for the enqueue/ready and
// forwarding rules, plus hand-written sequences for drain order, x0 writes,
// ack timeout and reset during an outstanding write.
module tb_reg_writeback;
    import rv_wb_pkg::*;

    localparam int DEPTH = 4;

    logic clk;
    logic rst_n;
    logic manual_ack;
    logic auto_ack;
    logic auto_en;
    logic pend;

    int total;
    int bad;

    int unsigned     log_rd [$];
    logic [31:0]     log_data [$];

    reg_writeback_if #(.DEPTH(DEPTH)) intf ();

    reg_writeback #(.DEPTH(DEPTH), .ACK_TIMEOUT(15)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .wb     (intf.slave)
    );

    assign intf.ack_write_i = manual_ack | auto_ack;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        lv;
        logic [4:0]  lrd;
        logic [31:0] ld;
        logic        av;
        logic [4:0]  ard;
        logic [31:0] ad;
        logic [4:0]  rs1;
        logic        exp_lr;
        logic        exp_ar;
        logic [2:0]  exp_cnt;
        logic        exp_hit;
        logic [31:0] exp_fd;
    } vec_t;

    vec_t vecs [7];

    function automatic vec_t mk(logic lv, logic [4:0] lrd, logic [31:0] ld,
                                logic av, logic [4:0] ard, logic [31:0] ad,
                                logic [4:0] rs1, logic exp_lr, logic exp_ar,
                                logic [2:0] exp_cnt, logic exp_hit, logic [31:0] exp_fd);
        vec_t v;
        v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.av = av; v.ard = ard; v.ad = ad;
        v.rs1 = rs1; v.exp_lr = exp_lr; v.exp_ar = exp_ar;
        v.exp_cnt = exp_cnt; v.exp_hit = exp_hit; v.exp_fd = exp_fd;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Register-file model: logs every strobe and, when enabled, acks in the
    // cycle after the strobe (or as soon as enabled if the ack was held back).
    initial begin
        auto_ack = 1'b0;
        pend     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                pend     = 1'b0;
                auto_ack = 1'b0;
            end else begin
                if (auto_ack) begin
                    auto_ack = 1'b0;
                end else if (pend && auto_en) begin
                    auto_ack = 1'b1;
                    pend     = 1'b0;
                end
                if (intf.stb_write_o) begin
                    pend = 1'b1;
                    log_rd.push_back(32'(intf.op_rd_o));
                    log_data.push_back(intf.reg_rd_o);
                end
            end
        end
    end

    task automatic idle_inputs();
        intf.lsu_valid_i = 1'b0;
        intf.lsu_rd_i    = '0;
        intf.lsu_data_i  = '0;
        intf.alu_valid_i = 1'b0;
        intf.alu_rd_i    = '0;
        intf.alu_data_i  = '0;
        intf.fwd_rs1_i   = '0;
        intf.fwd_rs2_i   = '0;
    endtask

    task automatic apply_reset();
        rst_n      = 1'b0;
        auto_en    = 1'b0;
        manual_ack = 1'b0;
        idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        log_rd.delete();
        log_data.delete();
        rst_n = 1'b1;
    endtask

    task automatic wait_drain(input string name, input int max_cycles);
        int n;
        n = 0;
        while (intf.count_o != '0 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk(name, 32'(intf.count_o), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        total = 0;
        bad   = 0;
        apply_reset();

        // Reset state
        chk("rst_count", 32'(intf.count_o), 0);
        chk("rst_stb", 32'(intf.stb_write_o), 0);
        chk("rst_op_rd", 32'(intf.op_rd_o), 0);
        chk("rst_reg_rd", intf.reg_rd_o, 0);
        chk("rst_err", 32'(intf.err_timeout_o), 0);

        // Single ALU write, acked one cycle after the strobe
        auto_en = 1'b1;
        intf.alu_valid_i = 1'b1;
        intf.alu_rd_i    = 5'd5;
        intf.alu_data_i  = 32'hDEADBEEF;
        #1 chk("single_alu_ready", 32'(intf.alu_ready_o), 1);
        @(posedge clk); #1;
        chk("single_count1", 32'(intf.count_o), 1);
        @(negedge clk);
        idle_inputs();
        wait_drain("single_drain", 20);
        chk("single_nwrites", 32'(log_rd.size()), 1);
        if (log_rd.size() >= 1) begin
            chk("single_rd", log_rd[0], 5);
            chk("single_data", log_data[0], 32'hDEADBEEF);
        end
        $display("seq single: writes=%0d", log_rd.size());

        // Same-cycle LSU and ALU to the same register
        apply_reset();
        intf.lsu_valid_i = 1'b1; intf.lsu_rd_i = 5'd3; intf.lsu_data_i = 32'h11;
        intf.alu_valid_i = 1'b1; intf.alu_rd_i = 5'd3; intf.alu_data_i = 32'h22;
        #1;
        chk("pair_lsu_ready", 32'(intf.lsu_ready_o), 1);
        chk("pair_alu_ready", 32'(intf.alu_ready_o), 1);
        @(posedge clk); #1;
        chk("pair_count", 32'(intf.count_o), 2);
        @(negedge clk);
        idle_inputs();
        intf.fwd_rs1_i = 5'd3;
        intf.fwd_rs2_i = 5'd3;
        #1;
        chk("pair_hit1", 32'(intf.fwd_hit1_o), 1);
        chk("pair_data1", intf.fwd_data1_o, 32'h22);
        chk("pair_hit2", 32'(intf.fwd_hit2_o), 1);
        chk("pair_data2", intf.fwd_data2_o, 32'h22);
        auto_en = 1'b1;
        wait_drain("pair_drain", 30);
        chk("pair_nwrites", 32'(log_rd.size()), 2);
        if (log_data.size() >= 2) begin
            chk("pair_first", log_data[0], 32'h11);
            chk("pair_second", log_data[1], 32'h22);
        end
        chk("pair_hit_after_drain", 32'(intf.fwd_hit1_o), 0);
        $display("seq pair: writes=%0d", log_rd.size());

        // Vector table: fill with ack withheld
        vecs[0] = mk(1, 5'd1, 32'hA1, 0, 5'd0, 32'h0,    5'd1, 1, 1, 3'd1, 1, 32'hA1);
        vecs[1] = mk(0, 5'd0, 32'h0,  1, 5'd0, 32'hFFFF, 5'd0, 1, 1, 3'd1, 0, 32'h0);
        vecs[2] = mk(1, 5'd2, 32'hA2, 1, 5'd3, 32'hA3,   5'd3, 1, 1, 3'd3, 1, 32'hA3);
        vecs[3] = mk(1, 5'd4, 32'hA4, 1, 5'd5, 32'hA5,   5'd5, 1, 0, 3'd4, 0, 32'h0);
        vecs[4] = mk(0, 5'd0, 32'h0,  1, 5'd6, 32'hA6,   5'd4, 0, 0, 3'd4, 1, 32'hA4);
        vecs[5] = mk(1, 5'd1, 32'hB1, 0, 5'd0, 32'h0,    5'd1, 0, 0, 3'd4, 1, 32'hA1);
        vecs[6] = mk(0, 5'd0, 32'h0,  0, 5'd0, 32'h0,    5'd2, 0, 0, 3'd4, 1, 32'hA2);
        apply_reset();
        for (int i = 0; i < 7; i++) begin
            if (i != 0) @(negedge clk);
            intf.lsu_valid_i = vecs[i].lv;
            intf.lsu_rd_i    = vecs[i].lrd;
            intf.lsu_data_i  = vecs[i].ld;
            intf.alu_valid_i = vecs[i].av;
            intf.alu_rd_i    = vecs[i].ard;
            intf.alu_data_i  = vecs[i].ad;
            intf.fwd_rs1_i   = vecs[i].rs1;
            #1;
            chk($sformatf("vec%0d_lsu_ready", i), 32'(intf.lsu_ready_o), 32'(vecs[i].exp_lr));
            chk($sformatf("vec%0d_alu_ready", i), 32'(intf.alu_ready_o), 32'(vecs[i].exp_ar));
            @(posedge clk); #1;
            chk($sformatf("vec%0d_count", i), 32'(intf.count_o), 32'(vecs[i].exp_cnt));
            chk($sformatf("vec%0d_hit", i), 32'(intf.fwd_hit1_o), 32'(vecs[i].exp_hit));
            if (vecs[i].exp_hit)
                chk($sformatf("vec%0d_fwd_data", i), intf.fwd_data1_o, vecs[i].exp_fd);
            $display("vec %0d: lsu v=%0d rd=%0d alu v=%0d rd=%0d -> count=%0d hit=%0d",
                     i, vecs[i].lv, vecs[i].lrd, vecs[i].av, vecs[i].ard,
                     intf.count_o, intf.fwd_hit1_o);
        end
        @(negedge clk);
        idle_inputs();
        auto_en = 1'b1;
        wait_drain("table_drain", 60);
        chk("table_nwrites", 32'(log_rd.size()), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < log_rd.size()) begin
                chk($sformatf("table_wr%0d_rd", i), log_rd[i], 32'(i + 1));
                chk($sformatf("table_wr%0d_data", i), log_data[i], 32'hA1 + 32'(i));
            end
        end
        chk("table_no_err", 32'(intf.err_timeout_o), 0);

        // Write to x0 is handshaken but never queued
        apply_reset();
        auto_en = 1'b1;
        intf.alu_valid_i = 1'b1; intf.alu_rd_i = 5'd0; intf.alu_data_i = 32'h55;
        intf.fwd_rs2_i = 5'd0;
        #1 chk("x0_ready", 32'(intf.alu_ready_o), 1);
        @(posedge clk); #1;
        chk("x0_count", 32'(intf.count_o), 0);
        chk("x0_hit2", 32'(intf.fwd_hit2_o), 0);
        @(negedge clk);
        idle_inputs();
        repeat (4) @(negedge clk);
        chk("x0_no_strobe", 32'(log_rd.size()), 0);
        $display("seq x0: writes=%0d", log_rd.size());

        // Ack timeout
        apply_reset();
        intf.alu_valid_i = 1'b1; intf.alu_rd_i = 5'd7; intf.alu_data_i = 32'h77;
        @(negedge clk);
        idle_inputs();
        n = 0;
        while (!intf.stb_write_o && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("to_strobe_seen", 32'(intf.stb_write_o), 1);
        n = 0;
        while (!intf.err_timeout_o && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("to_cycles", 32'(n), 15);
        chk("to_count_held", 32'(intf.count_o), 1);
        auto_en = 1'b1;
        wait_drain("to_drain", 20);
        chk("to_err_sticky", 32'(intf.err_timeout_o), 1);
        chk("to_nwrites", 32'(log_rd.size()), 1);
        if (log_data.size() >= 1) chk("to_data", log_data[0], 32'h77);
        $display("seq timeout: cycles=%0d writes=%0d", n, log_rd.size());

        // Reset while a write is outstanding
        apply_reset();
        intf.lsu_valid_i = 1'b1; intf.lsu_rd_i = 5'd1; intf.lsu_data_i = 32'h10;
        intf.alu_valid_i = 1'b1; intf.alu_rd_i = 5'd2; intf.alu_data_i = 32'h20;
        @(negedge clk);
        intf.lsu_valid_i = 1'b0;
        intf.alu_rd_i = 5'd3; intf.alu_data_i = 32'h30;
        @(negedge clk);
        idle_inputs();
        intf.fwd_rs1_i = 5'd1;
        #1;
        chk("rstw_count3", 32'(intf.count_o), 3);
        chk("rstw_op_rd", 32'(intf.op_rd_o), 1);
        chk("rstw_reg_rd", intf.reg_rd_o, 32'h10);
        #2 rst_n = 1'b0;
        #1;
        chk("rstw_count0", 32'(intf.count_o), 0);
        chk("rstw_stb", 32'(intf.stb_write_o), 0);
        chk("rstw_op0", 32'(intf.op_rd_o), 0);
        chk("rstw_reg0", intf.reg_rd_o, 0);
        chk("rstw_hit", 32'(intf.fwd_hit1_o), 0);
        log_rd.delete();
        log_data.delete();
        @(negedge clk);
        rst_n = 1'b1;
        manual_ack = 1'b1;
        @(negedge clk);
        manual_ack = 1'b0;
        repeat (4) @(negedge clk);
        chk("rstw_stray_count", 32'(intf.count_o), 0);
        chk("rstw_stray_strobe", 32'(log_rd.size()), 0);
        $display("seq reset_in_flight: count=%0d writes=%0d", intf.count_o, log_rd.size());

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/reg_writeback.md
Name: reg_writeback

Overview:
Writeback buffer directly upstream of the CPU register file write port. Accepts results from the ALU and the load/store unit and queues them in a small in-order FIFO. Drains the FIFO one entry at a time through the register file's strobe/ack write handshake. Lets the operand-read path forward values whose writes are still pending.

Parameters:
DEPTH, 4, FIFO entries; power of two, at least 2.
ACK_TIMEOUT, 15, cycles spent in WAIT_ACK before err_timeout_o is raised; at least 2.

Ports:
clk_i  in  1  clock; all state updates on posedge
rst_ni  in  1  reset, asynchronous, active-low
lsu_valid_i  in  1  load result offered
lsu_rd_i  in  5  load destination register index
lsu_data_i  in  32  load result
lsu_ready_o  out  1  load result accepted when valid&ready
alu_valid_i  in  1  ALU result offered
alu_rd_i  in  5  ALU destination register index
alu_data_i  in  32  ALU result
alu_ready_o  out  1  ALU result accepted when valid&ready
stb_write_o  out  1  one-cycle write strobe to the register file
op_rd_o  out  5  register index being written
reg_rd_o  out  32  value being written
ack_write_i  in  1  write-complete pulse from the register file
fwd_rs1_i  in  5  first operand index to look up
fwd_rs2_i  in  5  second operand index to look up
fwd_hit1_o  out  1  a pending write to fwd_rs1_i exists
fwd_data1_o  out  32  youngest pending value for fwd_rs1_i
fwd_hit2_o  out  1  a pending write to fwd_rs2_i exists
fwd_data2_o  out  32  youngest pending value for fwd_rs2_i
count_o  out  $clog2(DEPTH)+1  number of queued entries
err_timeout_o  out  1  sticky: an acknowledge was overdue

Behaviour:
- Reset (async assert, sync release): FIFO empty, count_o=0, state IDLE, stb_write_o=0, op_rd_o=0, reg_rd_o=0, err_timeout_o=0, timeout counter=0. An in-flight write is abandoned; a late ack_write_i after reset is ignored in IDLE.
- Enqueue (combinational ready, free = DEPTH-count):
  - lsu_ready_o = (free>=1).
  - alu_ready_o = lsu_valid_i ? (free>=2) : (free>=1).
  - When both are accepted in the same cycle, the LSU entry is written first (older), then the ALU entry.
  - A result with rd=0 is accepted (ready rules still apply) but not queued.
- A push lands at the tail on the posedge. It is visible to forwarding and to the FSM from the next cycle.
- FSM states: IDLE, WAIT_ACK.
  - IDLE and count>0: next cycle stb_write_o=1 for exactly one cycle, op_rd_o/reg_rd_o = head entry, go to WAIT_ACK, timer cleared.
  - WAIT_ACK: op_rd_o/reg_rd_o stay stable. stb_write_o=0 after the first cycle. Timer increments.
  - ack_write_i=1 in WAIT_ACK: head popped on that posedge, back to IDLE.
  - Sustained throughput is one write per 3 cycles with a 1-cycle-ack register file.
  - Timer reaching ACK_TIMEOUT: err_timeout_o<=1 (sticky until reset). Keep waiting; never re-strobe.
  - ack_write_i in IDLE is ignored.
- Simultaneous push and pop: both take effect; count = count + pushes - 1. Full FIFO plus pop in the same cycle does not raise ready; ready is based on pre-pop count.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Forwarding is combinational over all occupied entries, including the head in WAIT_ACK.
  - Youngest matching entry wins. An index of 0 never hits.
  - Data is no longer forwarded after the ack pop, because the register file then holds it.
- Stalls never drop or reorder entries. Register-file writes occur strictly in acceptance order.

Decomposition:
- Package rv_wb_pkg: wb_entry_t packed struct {rd[4:0], data[31:0]}, wb_state_t enum {IDLE, WAIT_ACK}, REG_IDX_W=5, XLEN=32.
- Sub-module wb_fifo: circular buffer with dual-slot push, single pop, count, and a flattened entry/occupancy view for the forwarding search.
- reg_writeback holds the ready logic, FSM, timeout counter and forwarding priority mux.

Test Plan:
- ALU push rd=5 data=0xDEADBEEF, register-file model acks 1 cycle after the strobe -> one stb_write_o pulse with op_rd_o=5, reg_rd_o=0xDEADBEEF; count_o goes 1 then 0.
- Same-cycle LSU rd=3/0x11 and ALU rd=3/0x22 -> writes issued in order 0x11 then 0x22; while both are pending, fwd_rs1_i=3 yields hit=1, data=0x22.
- Fill 4 entries with ack withheld -> both ready signals 0; lsu_valid_i=1 with count=3 -> alu_ready_o=0, lsu_ready_o=1.
- Push with rd=0 -> ready=1, count_o stays 0, no strobe; fwd_rs2_i=0 -> hit=0.
- Ack withheld 15 cycles -> err_timeout_o=1 and stays set after a later ack; the entry pops normally.
- Assert rst_ni low in WAIT_ACK with 3 entries queued -> all outputs 0 immediately; a stray ack after release causes no pop or strobe.
